// File: rtl/hilo_pkg.sv
// ============================================================================
// Module  : hilo_pkg
// Brief   : Op encodings, FSM state codes and divider constants for hilo_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_DIVU = 3'd5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DIV_RUN = 2'd1;
    localparam logic [1:0] ST_FINISH  = 2'd2;

    localparam int         DIV_ITERS = 32;
    localparam logic [5:0] DIV_LAST  = 6'(DIV_ITERS - 1);

    // Magnitude of a two's-complement word; 32'h80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division iteration (remainder, q bit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step (
    input  logic [31:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] w_shifted;
    logic [33:0] w_diff;
    logic        w_unused_diff;

    assign w_shifted = {rem_in, dividend_bit};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
    assign q_bit     = ~w_diff[33];

    // Either result is below the divisor, so 32 bits always suffice.
    assign rem_out       = q_bit ? w_diff[31:0] : w_shifted[31:0];
    assign w_unused_diff = w_diff[32];

endmodule

`default_nettype wire

// File: rtl/hilo_unit.sv
// ============================================================================
// Module  : hilo_unit
// Brief   : HI/LO register file with MULT/MTHI/MTLO and an optional iterative
//           divider, enabled by defining HILO_DIV_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_unit
    import hilo_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] ProdHI,
    input  logic [31:0] ProdLO,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_finish;
    logic [31:0] w_quot_final;
    logic [31:0] w_rem_final;

`ifdef HILO_DIV_EN
    logic [1:0]  r_state;
    logic [5:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] w_rem_next;
    logic        w_q_bit;
    logic        w_is_div;
    logic        w_signed;

    div_step u_div_step (
        .rem_in       (r_rem),
        .dividend_bit (r_quot[31]),
        .divisor      (r_divisor),
        .rem_out      (w_rem_next),
        .q_bit        (w_q_bit)
    );

    assign w_accept     = Start && (r_state == ST_IDLE);
    assign w_is_div     = (Op == OP_DIV) || (Op == OP_DIVU);
    assign w_signed     = (Op == OP_DIV);
    assign w_div_zero   = w_accept && w_is_div && (B == 32'h0);
    assign w_finish     = (r_state == ST_FINISH);
    assign Busy         = (r_state == ST_DIV_RUN);
    assign w_quot_final = r_neg_q ? (~r_quot + 32'd1) : r_quot;
    assign w_rem_final  = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    // r_quot starts as the dividend; its MSB feeds each step while quotient
    // bits shift in from the bottom.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_count   <= 6'd0;
            r_rem     <= 32'h0;
            r_quot    <= 32'h0;
            r_divisor <= 32'h0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_div && (B != 32'h0)) begin
                        r_rem     <= 32'h0;
                        r_quot    <= w_signed ? abs32(A) : A;
                        r_divisor <= w_signed ? abs32(B) : B;
                        r_neg_q   <= w_signed && (A[31] ^ B[31]);
                        r_neg_r   <= w_signed && A[31];
                        r_count   <= 6'd0;
                        r_state   <= ST_DIV_RUN;
                    end
                end
                ST_DIV_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= {r_quot[30:0], w_q_bit};
                    r_count <= r_count + 6'd1;
                    if (r_count == DIV_LAST) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end
`else
    logic w_unused_b;

    assign w_accept     = Start;
    assign w_div_zero   = 1'b0;
    assign w_finish     = 1'b0;
    assign Busy         = 1'b0;
    assign w_quot_final = 32'h0;
    assign w_rem_final  = 32'h0;
    assign w_unused_b   = ^B;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi   <= RESET_VAL;
            r_lo   <= RESET_VAL;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_finish) begin
                r_hi   <= w_rem_final;
                r_lo   <= w_quot_final;
                r_done <= 1'b1;
            end else if (w_div_zero) begin
                r_hi   <= A;
                r_lo   <= 32'hFFFF_FFFF;
                r_done <= 1'b1;
            end else if (w_accept) begin
                case (Op)
                    OP_MULT: begin
                        r_hi   <= ProdHI;
                        r_lo   <= ProdLO;
                        r_done <= 1'b1;
                    end
                    OP_MTHI: begin
                        r_hi   <= A;
                        r_done <= 1'b1;
                    end
                    OP_MTLO: begin
                        r_lo   <= A;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign Done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ============================================================================
// Module  : tb_hilo_unit
// Brief   : Scoreboard bench for hilo_unit; divide vectors run when HILO_DIV_EN
//           is defined, otherwise DIV/DIVU are exercised as no-ops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_unit;
    import hilo_pkg::*;

    localparam logic [31:0] RV = 32'hA5A5_0001;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ProdHI;
    logic [31:0] ProdLO;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    hilo_unit #(.RESET_VAL(RV)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .ProdHI (ProdHI),
        .ProdLO (ProdLO),
        .HI     (HI),
        .LO     (LO),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending result");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_hi", HI, e[63:32]);
                    chk("done_lo", LO, e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ph, input logic [31:0] pl);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b; ProdHI = ph; ProdLO = pl;
        @(negedge Clk);
        Start = 1'b0; Op = OP_NOP;
    endtask

`ifdef HILO_DIV_EN
    task automatic run_div(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input int exp_lat, input int exp_busy, input int inject_k);
        int k;
        int busy_cnt;
        exp_q.push_back({ehi, elo});
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        k = 0;
        busy_cnt = 0;
        do begin
            @(negedge Clk);
            k++;
            if (k == 1) begin
                Start = 1'b0; Op = OP_NOP;
            end
            if (k == inject_k) begin
                Start = 1'b1; Op = OP_MULT; ProdHI = 32'h5555_5555; ProdLO = 32'h6666_6666;
            end
            if (k == inject_k + 1) begin
                Start = 1'b0; Op = OP_NOP;
            end
            if (Busy === 1'b1) busy_cnt++;
        end while (Done !== 1'b1 && k < 100);
        chk({name, "_latency"}, k, exp_lat);
        chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    endtask
`endif

    initial begin : stimulus
        Reset = 1'b1; Start = 1'b0; Op = OP_NOP;
        A = 32'h0; B = 32'h0; ProdHI = 32'h0; ProdLO = 32'h0;
        repeat (3) @(negedge Clk);
        chk("reset_hi", HI, RV);
        chk("reset_lo", LO, RV);
        chk("reset_busy", {31'b0, Busy}, 32'h0);
        chk("reset_done", {31'b0, Done}, 32'h0);
        Reset = 1'b0;

        exp_q.push_back({32'h1, 32'h2});
        issue(OP_MULT, 32'h0, 32'h0, 32'h1, 32'h2);
        @(negedge Clk);
        chk("done_pulse_width", {31'b0, Done}, 32'h0);

        exp_q.push_back({32'hDEAD_BEEF, 32'h2});
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        exp_q.push_back({32'hDEAD_BEEF, 32'h1234_5678});
        issue(OP_MTLO, 32'h1234_5678, 32'h0, 32'h0, 32'h0);

        issue(OP_NOP, 32'h1111_1111, 32'h2, 32'h3333_3333, 32'h4444_4444);
        issue(3'd6,   32'h1111_1111, 32'h2, 32'h3333_3333, 32'h4444_4444);
        issue(3'd7,   32'h1111_1111, 32'h2, 32'h3333_3333, 32'h4444_4444);
        repeat (2) @(negedge Clk);
        chk("nop_hold_hi", HI, 32'hDEAD_BEEF);
        chk("nop_hold_lo", LO, 32'h1234_5678);

`ifdef HILO_DIV_EN
        run_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 32, 0);
        run_div("divu_ff_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 34, 32, 5);
        run_div("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 32, 0);
        run_div("div_7_m2",   OP_DIV,  32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 34, 32, 0);
        run_div("div_m7_m2",  OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3, 34, 32, 0);
        run_div("div_by_zero", OP_DIV, 32'd100, 32'h0, 32'd100, 32'hFFFF_FFFF, 1, 0, 0);

        begin : reset_abort
            int busy_cnt;
            @(negedge Clk);
            Start = 1'b1; Op = OP_DIV; A = 32'd50; B = 32'd5;
            for (int k = 1; k <= 10; k++) begin
                @(negedge Clk);
                if (k == 1) begin
                    Start = 1'b0; Op = OP_NOP;
                end
            end
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
            chk("abort_hi", HI, RV);
            chk("abort_lo", LO, RV);
            chk("abort_busy", {31'b0, Busy}, 32'h0);
            chk("abort_done", {31'b0, Done}, 32'h0);
            busy_cnt = 0;
            repeat (40) begin
                @(negedge Clk);
                if (Busy === 1'b1) busy_cnt++;
            end
            chk("abort_busy_after", busy_cnt, 0);
            chk("abort_hold_lo", LO, RV);
        end
`else
        begin : div_disabled
            int busy_cnt;
            busy_cnt = 0;
            issue(OP_DIV,  32'd100, 32'h0, 32'h0, 32'h0);
            issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0);
            repeat (5) begin
                @(negedge Clk);
                if (Busy === 1'b1) busy_cnt++;
            end
            chk("nodiv_busy", busy_cnt, 0);
            chk("nodiv_hi", HI, 32'hDEAD_BEEF);
            chk("nodiv_lo", LO, 32'h1234_5678);
        end
`endif

        exp_q.push_back({32'h7, 32'h8});
        issue(OP_MULT, 32'h0, 32'h0, 32'h7, 32'h8);
        repeat (5) @(negedge Clk);
        chk("pending_results", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
